// File: rtl/pueo_uram_pkg.sv
// Shared constants and FSM encoding for the URAM event buffer.
package pueo_uram_pkg;

  localparam int unsigned URAM_WIDTH       = 72;
  localparam int unsigned SAMPLES_PER_WORD = 6;

  typedef logic [1:0] fsm_t;
  localparam fsm_t IDLE  = 2'd0;
  localparam fsm_t READ  = 2'd1;
  localparam fsm_t DRAIN = 2'd2;

endpackage

// File: rtl/pueo_uram_skidfifo.sv
// First-word-fall-through skid FIFO; count_o feeds the read-issue credit check.
module pueo_uram_skidfifo #(
  parameter int unsigned Width = 577,
  parameter int unsigned Depth = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr_en_i,
  input  logic [Width-1:0]       wr_data_i,
  input  logic                   rd_en_i,
  output logic [Width-1:0]       rd_data_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned AW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q, count_d;
  logic             rd_ok;

  assign rd_ok     = rd_en_i && (count_q != '0);
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  // Output masked while empty so tdata/tlast read zero when nothing is valid.
  assign rd_data_o = empty_o ? '0 : mem_q[rptr_q];

  // Occupancy next-state.
  always_comb begin
    count_d = count_q + (AW+1)'(wr_en_i) - (AW+1)'(rd_ok);
  end

  // Storage array; contents need no reset because of the empty mask.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wptr_q] <= wr_data_i;
  end

  // Pointers and occupancy register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en_i) wptr_q <= wptr_q + 1'b1;
      if (rd_ok)   rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pueo_uram_evbuf_v3.sv
// Multi-channel circular waveform buffer with triggered, backpressured window readout.
module pueo_uram_evbuf_v3
  import pueo_uram_pkg::*;
#(
  parameter int unsigned NCHAN      = 8,
  parameter int unsigned NBIT       = 12,
  parameter int unsigned ADDRLEN    = 14,
  parameter int unsigned RDLEN      = 1024,
  parameter int unsigned PRETRIG    = 256,
  parameter int unsigned RD_LATENCY = 6,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                                 memclk,
  input  logic                                 memclk_rst_i,
  input  logic                                 run_i,
  input  logic [NCHAN*SAMPLES_PER_WORD*NBIT-1:0] dat_i,
  output logic [ADDRLEN-1:0]                   wr_addr_o,
  input  logic [ADDRLEN-1:0]                   s_axis_tdata,
  input  logic                                 s_axis_tvalid,
  output logic                                 s_axis_tready,
  output logic [NCHAN*SAMPLES_PER_WORD*NBIT-1:0] m_axis_tdata,
  output logic                                 m_axis_tvalid,
  input  logic                                 m_axis_tready,
  output logic                                 m_axis_tlast,
  output logic                                 overrun_o
);

  localparam int unsigned WORDW = SAMPLES_PER_WORD * NBIT;
  localparam int unsigned DW    = NCHAN * WORDW;
  localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned ICW   = $clog2(RDLEN + 1);

  fsm_t                  state_q, state_d;
  logic                  rdy_q;
  logic [ADDRLEN-1:0]    wr_addr_q, rd_addr_q, rd_addr_d;
  logic [ICW-1:0]        issue_cnt_q, issue_cnt_d;
  logic                  overrun_q, overrun_d;
  logic [RD_LATENCY-1:0] vld_q, vld_d, last_q, last_d;
  logic [CW-1:0]         inflight, fifo_count;
  logic                  credit_ok, issue, issue_last, pop, fifo_empty;
  logic [DW-1:0]         rd_word;
  logic [DW:0]           fifo_out;

  assign wr_addr_o     = wr_addr_q;
  assign overrun_o     = overrun_q;
  // rdy_q keeps tready low while reset is asserted even though the FSM sits in IDLE.
  assign s_axis_tready = rdy_q && (state_q == IDLE);
  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_out[DW-1:0];
  assign m_axis_tlast  = fifo_out[DW];
  assign pop           = m_axis_tvalid && m_axis_tready;

  // Reads still in the memory pipeline, counted against FIFO space.
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < RD_LATENCY; i++) inflight = inflight + CW'(vld_q[i]);
  end

  assign credit_ok  = ((CW+1)'(fifo_count) + (CW+1)'(inflight)) < (CW+1)'(FIFO_DEPTH);
  assign issue      = (state_q == READ) && credit_ok;
  assign issue_last = issue && (issue_cnt_q == ICW'(RDLEN - 1));

  // Valid/last tags travel alongside the memory read pipeline.
  always_comb begin
    vld_d  = (vld_q << 1) | RD_LATENCY'(issue);
    last_d = (last_q << 1) | RD_LATENCY'(issue_last);
  end

  // Window FSM: accept trigger, issue RDLEN reads under credit, drain to tlast.
  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    issue_cnt_d = issue_cnt_q;
    overrun_d   = overrun_q;
    case (state_q)
      IDLE: begin
        if (s_axis_tvalid && s_axis_tready) begin
          rd_addr_d   = s_axis_tdata - ADDRLEN'(PRETRIG);
          issue_cnt_d = '0;
          overrun_d   = 1'b0;
          state_d     = READ;
        end
      end
      READ: begin
        // Writer caught up with the next word still to be read.
        if (run_i && (wr_addr_q == rd_addr_q)) overrun_d = 1'b1;
        if (issue) begin
          rd_addr_d   = rd_addr_q + 1'b1;
          issue_cnt_d = issue_cnt_q + 1'b1;
          if (issue_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && m_axis_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge memclk or posedge memclk_rst_i) begin
    if (memclk_rst_i) begin
      state_q     <= IDLE;
      rdy_q       <= 1'b0;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      issue_cnt_q <= '0;
      overrun_q   <= 1'b0;
      vld_q       <= '0;
      last_q      <= '0;
    end else begin
      state_q     <= state_d;
      rdy_q       <= 1'b1;
      if (run_i) wr_addr_q <= wr_addr_q + 1'b1;
      rd_addr_q   <= rd_addr_d;
      issue_cnt_q <= issue_cnt_d;
      overrun_q   <= overrun_d;
      vld_q       <= vld_d;
      last_q      <= last_d;
    end
  end

  for (genvar c = 0; c < NCHAN; c++) begin : g_chan
    logic [WORDW-1:0] mem_q  [2**ADDRLEN];
    logic [WORDW-1:0] pipe_q [RD_LATENCY];

    // Per-channel URAM: read-first on address collision, RD_LATENCY-deep output pipe.
    always_ff @(posedge memclk) begin
      if (run_i) mem_q[wr_addr_q] <= dat_i[c*WORDW +: WORDW];
      if (issue) pipe_q[0] <= mem_q[rd_addr_q];
      for (int unsigned i = 1; i < RD_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end

    assign rd_word[c*WORDW +: WORDW] = pipe_q[RD_LATENCY-1];
  end

  pueo_uram_skidfifo #(
    .Width (DW + 1),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (memclk),
    .rst_i     (memclk_rst_i),
    .wr_en_i   (vld_q[RD_LATENCY-1]),
    .wr_data_i ({last_q[RD_LATENCY-1], rd_word}),
    .rd_en_i   (pop),
    .rd_data_o (fifo_out),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

endmodule
